// File: rtl/seg7_mux_driver.sv
// Time-multiplexed 7-segment driver: staged nibble load, tear-free frame-boundary update,
// one digit per refresh slot, with leading-zero blanking, per-digit blink and a frame_done pulse.
module seg7_mux_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_HALF  = 25000000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

  logic [DIV_W-1:0]          div_cnt;
  logic [IDX_W-1:0]          idx;
  logic [BLK_W-1:0]          blink_cnt;
  logic                      phase;
  logic [4*NUM_DIGITS-1:0]   staging_val;
  logic [NUM_DIGITS-1:0]     staging_dp;
  logic [4*NUM_DIGITS-1:0]   shadow_val;
  logic [NUM_DIGITS-1:0]     shadow_dp;
  logic                      pending;

  logic                      slot_end;
  logic                      boundary;
  logic [NUM_DIGITS-1:0]     lz_mask;
  logic [3:0]                cur_nib;
  logic                      cur_dp;
  logic                      cur_blank;
  logic [NUM_DIGITS-1:0]     an_onehot;

  assign slot_end = (div_cnt == DIV_LAST);
  assign boundary = slot_end && (idx == IDX_LAST);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'b0111111;
      4'h1: code = 7'b0000110;
      4'h2: code = 7'b1011011;
      4'h3: code = 7'b1001111;
      4'h4: code = 7'b1100110;
      4'h5: code = 7'b1101101;
      4'h6: code = 7'b1111101;
      4'h7: code = 7'b0000111;
      4'h8: code = 7'b1111111;
      4'h9: code = 7'b1101111;
      4'hA: code = 7'b1110111;
      4'hB: code = 7'b1111100;
      4'hC: code = 7'b0111001;
      4'hD: code = 7'b1011110;
      4'hE: code = 7'b1111001;
      default: code = 7'b1110001;
    endcase
    return code;
  endfunction

  // load is a one-cycle strobe with no ready: every strobe is accepted. Off a boundary it
  // lands in staging (pending); on a boundary it goes straight to the shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      phase       <= 1'b0;
      staging_val <= '0;
      staging_dp  <= '0;
      shadow_val  <= '0;
      shadow_dp   <= '0;
      pending     <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      if (blink_cnt == BLK_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      frame_done <= boundary;
      if (load) begin
        staging_val <= value_in;
        staging_dp  <= dp_in;
      end
      if (boundary) begin
        pending <= 1'b0;
        if (load) begin
          shadow_val <= value_in;
          shadow_dp  <= dp_in;
        end else if (pending) begin
          shadow_val <= staging_val;
          shadow_dp  <= staging_dp;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Digit k is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    logic zero_above;
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (shadow_val[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_above && (k != 0);
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_onehot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib      = shadow_val[4*k +: 4];
        cur_dp       = shadow_dp[k];
        cur_blank    = (blank_lz && lz_mask[k]) || (phase && blink_en[k]);
        an_onehot[k] = 1'b1;
      end
    end
  end

  // Registered output stage: follows idx by one cycle; a blanked slot keeps its timing but
  // drives nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= {7{POL}};
      dp  <= POL;
      an  <= {NUM_DIGITS{POL}};
    end else if (cur_blank) begin
      seg <= {7{POL}};
      dp  <= POL;
      an  <= {NUM_DIGITS{POL}};
    end else begin
      seg <= hex_to_seg(cur_nib) ^ {7{POL}};
      dp  <= cur_dp ^ POL;
      an  <= an_onehot ^ {NUM_DIGITS{POL}};
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Scoreboard bench for seg7_mux_driver (4 digits, 4-cycle slots, 64-cycle blink, active-low).
// Expected slot images are tagged with their slot number and checked by an independent monitor.
module tb_seg7_mux_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  blink_en = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  seg7_mux_driver #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4),
    .BLINK_HALF (64),
    .ACTIVE_LOW (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .value_in  (value_in),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .blink_en  (blink_en),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  int   ecnt = 0;        // rising edges seen with rst low since the last reset
  logic in_rst = 1'b0;   // rst was high at the last rising edge

  always @(posedge clk) begin
    in_rst <= rst;
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [27:0] exp_q[$];   // {slot[15:0], an[3:0], seg[6:0], dp}
  logic [27:0] mon_e;
  int          mon_slot;

  function automatic logic [6:0] hex_code(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'h0: c = 7'b0111111;  4'h1: c = 7'b0000110;  4'h2: c = 7'b1011011;  4'h3: c = 7'b1001111;
      4'h4: c = 7'b1100110;  4'h5: c = 7'b1101101;  4'h6: c = 7'b1111101;  4'h7: c = 7'b0000111;
      4'h8: c = 7'b1111111;  4'h9: c = 7'b1101111;  4'hA: c = 7'b1110111;  4'hB: c = 7'b1111100;
      4'hC: c = 7'b0111001;  4'hD: c = 7'b1011110;  4'hE: c = 7'b1111001;  default: c = 7'b1110001;
    endcase
    return c;
  endfunction

  task automatic push_slot(input int slot, input int digit, input logic [3:0] nib,
                           input logic dpv, input logic blanked);
    logic [3:0]  a;
    logic [6:0]  s;
    logic        d;
    logic [15:0] sl;
    if (blanked) begin
      a = 4'hF;
      s = 7'h7F;
      d = 1'b1;
    end else begin
      a = ~(4'b0001 << digit);
      s = ~hex_code(nib);
      d = ~dpv;
    end
    sl = 16'(slot);
    exp_q.push_back({sl, a, s, d});
  endtask

  task automatic push_frame(input int f, input logic [15:0] v, input logic [3:0] dpv,
                            input logic [3:0] bmask);
    for (int k = 0; k < 4; k++) push_slot(4*f + k, k, v[4*k +: 4], dpv[k], bmask[k]);
  endtask

  // Monitor: reset image while in reset, frame_done every cycle, slot image mid-slot.
  always @(negedge clk) begin
    if (in_rst === 1'b1) begin
      checks++;
      if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_state: an=%b seg=%b dp=%b fd=%b required an=1111 seg=1111111 dp=1 fd=0",
                 an, seg, dp, frame_done);
      end
    end else if (ecnt > 0) begin
      checks++;
      if (frame_done !== (ecnt % 16 == 0)) begin
        errors++;
        $display("FAIL frame_done at cycle %0d: got %b required %b", ecnt, frame_done, (ecnt % 16 == 0));
      end
      if (ecnt % 4 == 2) begin
        mon_slot = (ecnt - 2) / 4;
        while (exp_q.size() > 0 && int'(exp_q[0][27:12]) < mon_slot) begin
          mon_e = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL slot_missed: slot %0d not observed (now slot %0d)", int'(mon_e[27:12]), mon_slot);
        end
        if (exp_q.size() > 0 && int'(exp_q[0][27:12]) == mon_slot) begin
          mon_e = exp_q.pop_front();
          checks++;
          if ({an, seg, dp} !== mon_e[11:0]) begin
            errors++;
            $display("FAIL slot %0d: an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
                     mon_slot, an, seg, dp, mon_e[11:8], mon_e[7:1], mon_e[0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic goto(input int e);
    int guard = 0;
    while (ecnt < e && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checks++;
    if (ecnt != e) begin
      errors++;
      $display("FAIL schedule: at cycle %0d required cycle %0d", ecnt, e);
    end
  endtask

  // Makes load visible at rising edge number e.
  task automatic do_load(input int e, input logic [15:0] v, input logic [3:0] dpv);
    goto(e - 1);
    value_in = v;
    dp_in    = dpv;
    load     = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Frame 0 shows the reset shadow; 0x1234 staged mid-frame appears in frame 1.
    push_frame(0, 16'h0000, 4'b0000, 4'b0000);
    do_load(2, 16'h1234, 4'b0010);
    push_frame(1, 16'h1234, 4'b0010, 4'b0000);

    // Two loads in one frame: only the later one is ever shown.
    do_load(20, 16'hABCD, 4'b1111);
    do_load(26, 16'h0005, 4'b0000);
    push_frame(2, 16'h0005, 4'b0000, 4'b0000);

    // Pending load then a load on the boundary: the boundary value wins and nothing stale follows.
    do_load(40, 16'h7777, 4'b0101);
    push_frame(3, 16'h5A3C, 4'b1000, 4'b0000);
    push_frame(4, 16'h5A3C, 4'b1000, 4'b0000);
    do_load(48, 16'h5A3C, 4'b1000);

    // Leading-zero blanking.
    do_load(70, 16'h0005, 4'b0001);
    goto(72);
    blank_lz = 1'b1;
    push_frame(5, 16'h0005, 4'b0001, 4'b1110);
    do_load(90, 16'h0000, 4'b0000);
    push_frame(6, 16'h0000, 4'b0000, 4'b1110);
    do_load(106, 16'h0102, 4'b0000);
    push_frame(7, 16'h0102, 4'b0000, 4'b1000);

    // Blink on digit 0: blank in cycles 64..127 and 192..255 of the blink counter.
    goto(129);
    blank_lz = 1'b0;
    blink_en = 4'b0001;
    do_load(130, 16'h4321, 4'b0000);
    push_frame(9,  16'h4321, 4'b0000, 4'b0000);
    push_frame(11, 16'h4321, 4'b0000, 4'b0000);
    push_frame(12, 16'h4321, 4'b0000, 4'b0001);
    push_frame(13, 16'h4321, 4'b0000, 4'b0001);
    push_frame(16, 16'h4321, 4'b0000, 4'b0000);

    // Pending load discarded by a mid-slot reset.
    do_load(275, 16'h9999, 4'b1111);
    goto(280);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_frame(0, 16'h0000, 4'b0000, 4'b0000);
    push_frame(1, 16'h0000, 4'b0000, 4'b0000);

    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected slots left, required 0", exp_q.size());
    end
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
